fpu_scheduler: RTL and testbench

Sequencing and writeback controller for the multi-cycle single-precision FPU used by ADD.S. It accepts an issue from the execute stage and steps the FPU datapath through its compare, operate, align and normalize stages, one per cycle. It holds the result and arbitrates the single FP register-file write port against LWC1 writeback, giving LWC1 priority. It also produces `fpu_working` and the decode-stage stall for RAW hazards on the in-flight destination.

---
 rtl/fpu_scheduler_if.sv | 37 +++
 rtl/fpu_scheduler.sv | 67 ++++++
 tb/tb_fpu_scheduler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_scheduler_if.sv
// fpu_scheduler_if: issue, datapath, writeback and hazard signals of the FPU scheduler
interface fpu_scheduler_if #(
    parameter int RegAddrWidth = 5,
    parameter int DataWidth    = 32
);
    logic                    start;
    logic [RegAddrWidth-1:0] fd_addr;
    logic                    start_ack;
    logic [3:0]              stage_en;
    logic [DataWidth-1:0]    fpu_result;
    logic                    mem_fp_write;
    logic [RegAddrWidth-1:0] mem_fp_dst;
    logic [DataWidth-1:0]    mem_fp_val;
    logic                    fp_we;
    logic [RegAddrWidth-1:0] fp_waddr;
    logic [DataWidth-1:0]    fp_wdata;
    logic                    fpu_working;
    logic [RegAddrWidth-1:0] busy_dst;
    logic                    d_fp_read;
    logic [RegAddrWidth-1:0] d_fs_a;
    logic [RegAddrWidth-1:0] d_ft_a;
    logic                    stall_d;

    modport master (
        output start, fd_addr, fpu_result, mem_fp_write, mem_fp_dst, mem_fp_val,
               d_fp_read, d_fs_a, d_ft_a,
        input  start_ack, stage_en, fp_we, fp_waddr, fp_wdata, fpu_working,
               busy_dst, stall_d
    );

    modport slave (
        input  start, fd_addr, fpu_result, mem_fp_write, mem_fp_dst, mem_fp_val,
               d_fp_read, d_fs_a, d_ft_a,
        output start_ack, stage_en, fp_we, fp_waddr, fp_wdata, fpu_working,
               busy_dst, stall_d
    );
endinterface

// File: rtl/fpu_scheduler.sv
// fpu_scheduler: sequences the multi-cycle FPU and arbitrates the FP write port against LWC1
module fpu_scheduler #(
    parameter int RegAddrWidth = 5,
    parameter int DataWidth    = 32
) (
    input logic            clk,
    input logic            reset,
    fpu_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMP, OPR, ALN, NRM, WB} state_t;

    state_t                  state, state_nxt;
    logic                    squash;
    logic [DataWidth-1:0]    result;
    logic [RegAddrWidth-1:0] dst;
    logic                    waw;
    logic                    wb_ok;

    // a younger LWC1 to our destination after CMP makes the FPU result stale
    assign waw   = bus.mem_fp_write && bus.mem_fp_dst == dst && state inside {OPR, ALN, NRM, WB};
    assign wb_ok = state == WB && !squash;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // squash flag, result capture and in-flight destination
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            squash <= 1'b0;
            result <= '0;
            dst    <= '0;
        end else begin
            squash <= state_nxt == IDLE ? 1'b0 : squash | waw;
            if (state == NRM) result <= bus.fpu_result;
            dst <= (state == IDLE && bus.start) ? bus.fd_addr : (state_nxt == IDLE ? '0 : dst);
        end
    end

    // next state and all outputs; LWC1 always owns the write port when it asks
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start ? CMP : IDLE;
            CMP:     state_nxt = OPR;
            OPR:     state_nxt = ALN;
            ALN:     state_nxt = NRM;
            NRM:     state_nxt = WB;
            WB:      state_nxt = bus.mem_fp_write ? WB : IDLE;
            default: state_nxt = IDLE;
        endcase
        bus.start_ack   = bus.start && state == IDLE;
        bus.stage_en    = state == CMP ? 4'b0001 :
                          state == OPR ? 4'b0010 :
                          state == ALN ? 4'b0100 :
                          state == NRM ? 4'b1000 : 4'b0000;
        bus.fpu_working = state != IDLE;
        bus.busy_dst    = dst;
        bus.stall_d     = state != IDLE &&
                          (bus.start || (bus.d_fp_read && (bus.d_fs_a == dst || bus.d_ft_a == dst)));
        bus.fp_we       = bus.mem_fp_write || wb_ok;
        bus.fp_waddr    = bus.mem_fp_write ? bus.mem_fp_dst : (wb_ok ? dst : '0);
        bus.fp_wdata    = bus.mem_fp_write ? bus.mem_fp_val : (wb_ok ? result : '0);
    end
endmodule

// File: tb/tb_fpu_scheduler.sv
// tb_fpu_scheduler: directed and random checks of fpu_scheduler against an op-age model
module tb_fpu_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;

    // model: one op in flight, tracked by cycles since issue
    bit          m_busy = 0;
    int          m_age = 0;
    logic [4:0]  m_dst = '0;
    logic [31:0] m_res = '0;
    bit          m_sq = 0;

    logic [3:0]  s_stage;
    logic        s_ack, s_work, s_stall, s_we;
    logic [4:0]  s_waddr, s_bdst;
    logic [31:0] s_wdata;

    fpu_scheduler_if bus ();
    fpu_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_in();
        bus.start = 0; bus.fd_addr = '0; bus.fpu_result = '0;
        bus.mem_fp_write = 0; bus.mem_fp_dst = '0; bus.mem_fp_val = '0;
        bus.d_fp_read = 0; bus.d_fs_a = '0; bus.d_ft_a = '0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_dst = '0; m_res = '0; m_sq = 0;
    endtask

    // compare one cycle against the model, then advance model and clock
    task automatic step();
        logic [3:0]  e_stage;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        bit          in_wb;
        #1;
        in_wb   = m_busy && m_age >= 5;
        e_stage = (m_busy && m_age >= 1 && m_age <= 4) ? 4'(1 << (m_age - 1)) : 4'd0;
        if (bus.mem_fp_write) begin
            e_we = 1; e_wa = bus.mem_fp_dst; e_wd = bus.mem_fp_val;
        end else if (in_wb && !m_sq) begin
            e_we = 1; e_wa = m_dst; e_wd = m_res;
        end else begin
            e_we = 0; e_wa = '0; e_wd = '0;
        end
        chk("stage_en", bus.stage_en, e_stage);
        chk("start_ack", bus.start_ack, bus.start && !m_busy);
        chk("fpu_working", bus.fpu_working, m_busy);
        chk("busy_dst", bus.busy_dst, m_busy ? m_dst : 5'd0);
        chk("stall_d", bus.stall_d, m_busy && (bus.start ||
            (bus.d_fp_read && (bus.d_fs_a == m_dst || bus.d_ft_a == m_dst))));
        chk("fp_we", bus.fp_we, e_we);
        chk("fp_waddr", bus.fp_waddr, e_wa);
        chk("fp_wdata", bus.fp_wdata, e_wd);
        s_stage = bus.stage_en; s_ack = bus.start_ack; s_work = bus.fpu_working;
        s_stall = bus.stall_d; s_we = bus.fp_we; s_waddr = bus.fp_waddr;
        s_wdata = bus.fp_wdata; s_bdst = bus.busy_dst;
        @(posedge clk);
        if (!m_busy) begin
            if (bus.start) begin
                m_busy = 1; m_age = 1; m_dst = bus.fd_addr; m_sq = 0;
            end
        end else begin
            if (bus.mem_fp_write && bus.mem_fp_dst == m_dst && m_age >= 2) m_sq = 1;
            if (m_age == 4) m_res = bus.fpu_result;
            if (m_age >= 5 && !bus.mem_fp_write) m_busy = 0;
            else m_age++;
        end
        @(negedge clk);
    endtask

    initial begin
        idle_in();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_stage", bus.stage_en, 0);
        chk("rst_work", bus.fpu_working, 0);
        chk("rst_we", bus.fp_we, 0);
        chk("rst_bdst", bus.busy_dst, 0);
        @(negedge clk);
        reset = 0;
        model_reset();

        // basic op to f3
        for (int c = 0; c <= 6; c++) begin
            idle_in();
            bus.start = c == 0; bus.fd_addr = 5'd3; bus.fpu_result = 32'h40400000;
            step();
            if (c >= 1 && c <= 4) chk("basic_stage", s_stage, 32'(1) << (c - 1));
            if (c == 0) chk("basic_ack", s_ack, 1);
            if (c == 5) begin
                chk("basic_we", s_we, 1);
                chk("basic_waddr", s_waddr, 3);
                chk("basic_wdata", s_wdata, 32'h40400000);
            end
            if (c == 6) chk("basic_idle", s_work, 0);
        end

        // LWC1 contention in WB
        for (int c = 0; c <= 8; c++) begin
            idle_in();
            bus.start = c == 0; bus.fd_addr = 5'd3; bus.fpu_result = 32'h40400000;
            bus.mem_fp_write = c == 5 || c == 6; bus.mem_fp_dst = 5'd7; bus.mem_fp_val = 32'h3F800000;
            step();
            if (c == 5 || c == 6) begin
                chk("cont_mem_waddr", s_waddr, 7);
                chk("cont_mem_wdata", s_wdata, 32'h3F800000);
            end
            if (c == 7) begin
                chk("cont_fpu_we", s_we, 1);
                chk("cont_fpu_waddr", s_waddr, 3);
                chk("cont_work7", s_work, 1);
            end
            if (c == 8) chk("cont_work8", s_work, 0);
        end

        // WAW squash (LWC1 in ALN) and no squash (LWC1 in CMP)
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c <= 6; c++) begin
                idle_in();
                bus.start = c == 0; bus.fd_addr = 5'd4; bus.fpu_result = 32'h12345678;
                bus.mem_fp_write = c == (k == 0 ? 3 : 1); bus.mem_fp_dst = 5'd4;
                bus.mem_fp_val = 32'h11111111;
                step();
                if (k == 0 && c == 5) chk("squash_we", s_we, 0);
                if (k == 1 && c == 5) begin
                    chk("cmp_lwc1_we", s_we, 1);
                    chk("cmp_lwc1_waddr", s_waddr, 4);
                end
                if (c == 6) chk("squash_idle", s_work, 0);
            end
        end

        // RAW stall: matching and non-matching sources
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c <= 6; c++) begin
                idle_in();
                bus.start = c == 0; bus.fd_addr = 5'd5; bus.d_fp_read = 1;
                bus.d_fs_a = k == 0 ? 5'd5 : 5'd6; bus.d_ft_a = k == 0 ? 5'd0 : 5'd2;
                step();
                if (k == 0) chk("raw_stall", s_stall, c >= 1 && c <= 5);
                if (k == 1 && c == 3) chk("raw_nostall", s_stall, 0);
            end
        end

        // start held while busy
        for (int c = 0; c <= 7; c++) begin
            idle_in();
            bus.start = 1; bus.fd_addr = 5'd8;
            step();
            chk("hold_ack", s_ack, c == 0 || c == 6);
            if (c <= 6) chk("hold_stall", s_stall, c >= 1 && c <= 5);
        end
        idle_in();
        repeat (8) step();

        // async reset while in ALN
        for (int c = 0; c < 3; c++) begin
            idle_in();
            bus.start = c == 0; bus.fd_addr = 5'd9;
            step();
        end
        idle_in();
        #2;
        chk("pre_rst_aln", bus.stage_en, 4'b0100);
        reset = 1;
        #1;
        chk("arst_stage", bus.stage_en, 0);
        chk("arst_work", bus.fpu_working, 0);
        chk("arst_we", bus.fp_we, 0);
        chk("arst_waddr", bus.fp_waddr, 0);
        chk("arst_wdata", bus.fp_wdata, 0);
        chk("arst_bdst", bus.busy_dst, 0);
        chk("arst_stall", bus.stall_d, 0);
        chk("arst_ack", bus.start_ack, 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        repeat (6) step();
        bus.start = 1; bus.fd_addr = 5'd10;
        step();
        chk("post_rst_ack", s_ack, 1);
        idle_in();
        repeat (6) step();

        // randomized traffic with small address space to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            bus.start = $urandom_range(3) == 0;
            bus.fd_addr = 5'($urandom_range(7));
            bus.fpu_result = $urandom;
            bus.mem_fp_write = $urandom_range(2) == 0;
            bus.mem_fp_dst = 5'($urandom_range(7));
            bus.mem_fp_val = $urandom;
            bus.d_fp_read = 1'($urandom_range(1));
            bus.d_fs_a = 5'($urandom_range(7));
            bus.d_ft_a = 5'($urandom_range(7));
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
